coherence_bus_arbiter: RTL and testbench
========================================

COHERENCE_BUS_ARBITER -- requirements
Module: coherence_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_L1_CACHES, default 4: number of L1 requester ports.
REQ-002 SHALL have parameter MAX_HOLD, default 64: cycles a grant may be held before a timeout flag is raised.
REQ-003 SHALL derive localparams BUS_PORTS = NUM_L1_CACHES+1, MEM_PORT = BUS_PORTS-1, BUS_SIG_WIDTH = log2(BUS_PORTS).
REQ-004 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port request  input  BUS_PORTS  per-port bus request; bit MEM_PORT is the memory-side interface.
REQ-007 SHALL have port grant  output  BUS_PORTS  one-hot grant, registered.
REQ-008 SHALL have port grant_id  output  BUS_SIG_WIDTH  index of granted port, valid when bus_busy=1.
REQ-009 SHALL have port bus_busy  output  1  high while any grant is active.
REQ-010 SHALL have port hold_timeout  output  1  single-cycle pulse when one grant reaches MAX_HOLD cycles.

Function
REQ-011 SHALL implement three states: IDLE, GRANT, TURN (turnaround).
REQ-012 In IDLE with any request bit high, SHALL go to GRANT next cycle with grant/grant_id/bus_busy registered; latency is request -> grant 1 cycle.
REQ-013 In IDLE, MEM_PORT SHALL have absolute priority over all L1 ports.
REQ-014 Among L1 ports, SHALL select round-robin: first requesting port at or after rr_ptr, wrapping from NUM_L1_CACHES-1 to 0.
REQ-015 In GRANT, grant SHALL stay fixed while request[grant_id] stays high; other requests SHALL NOT preempt it, MEM_PORT included.
REQ-016 When request[grant_id] drops in GRANT, SHALL go to TURN next cycle with grant=0, bus_busy=0.
REQ-017 On entering TURN from an L1 grant, rr_ptr SHALL become (grant_id+1) mod NUM_L1_CACHES; after a MEM_PORT grant, rr_ptr SHALL stay unchanged.
REQ-018 TURN SHALL last exactly one cycle and then go to IDLE, so back-to-back grants have at least one idle bus cycle between them.
REQ-019 A hold counter SHALL clear on entry to GRANT and increment each cycle in GRANT, saturating at MAX_HOLD.
REQ-020 hold_timeout SHALL pulse for exactly one cycle when the hold counter first equals MAX_HOLD; the grant SHALL NOT be revoked.
REQ-021 A request asserted and dropped entirely within TURN SHALL be ignored; requesters SHALL hold request until granted.
REQ-022 grant SHALL never have more than one bit set; grant_id SHALL be 0 when bus_busy=0.

Reset
REQ-023 On reset, state SHALL go to IDLE, with grant=0, grant_id=0, bus_busy=0, hold_timeout=0, rr_ptr=0, hold counter=0.
REQ-024 Reset asserted mid-grant SHALL drop grant asynchronously in the same cycle; no TURN cycle follows.
REQ-025 After reset deasserts, the first arbitration SHALL take place in the first IDLE cycle.

Structure
REQ-026 State encoding and the log2 function SHALL live in the shared cache-hierarchy params include; BUS_PORTS/MEM_PORT SHALL be computed locally.
REQ-027 The round-robin priority picker SHALL be one combinational sub-module, rr_priority_select (inputs: requests, pointer; outputs: one-hot, index, found).
REQ-028 Counter width SHALL be log2(MAX_HOLD+1) bits.

Verification
REQ-029 request=5'b00001 held 3 cycles -> grant=00001 one cycle after assertion and held 3 cycles, then a 1-cycle TURN, then IDLE; rr_ptr=1.
REQ-030 request=5'b01111 held continuously, each holder dropping after 2 cycles -> grant order port 0,1,2,3,0 with one idle cycle between grants.
REQ-031 request=5'b11000 in IDLE with rr_ptr=0 -> grant=10000 (MEM_PORT), grant_id=4; rr_ptr unchanged after release.
REQ-032 Port 2 granted, then MEM_PORT requests -> port 2 keeps grant until it drops; MEM_PORT is granted in the next IDLE.
REQ-033 With MAX_HOLD=4, port 1 holds 10 cycles -> hold_timeout pulses once, 4 cycles after grant, and grant stays active.
REQ-034 reset asserted while port 3 granted -> grant=0 and bus_busy=0 immediately; after release, request=5'b01000 -> grant=01000 one cycle later with rr_ptr=0.

Source files
------------

// File: rtl/coherence_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coherence_bus_arbiter_pkg
// Description : Shared cache-hierarchy definitions for the coherence bus
//               arbiter: arbiter state encoding and a ceiling-log2 helper
//               used to size indices and counters.
// Revision    : 1.0 - initial release
// ============================================================================
package coherence_bus_arbiter_pkg;

    // Bus arbitration phases. TURN is the single dead cycle between grants.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_t;

    // Ceiling log2 with a floor of 1 so that a single-entry index still
    // gets a real bit.
    function automatic int log2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : coherence_bus_arbiter_pkg
`default_nettype wire

// File: rtl/coherence_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : coherence_bus_arbiter_if
// Description : Bus request/grant bundle between the L1/memory requesters
//               and the coherence bus arbiter.
//                 request      - per-port request, top bit is memory side
//                 grant        - one-hot registered grant
//                 grant_id     - index of granted port (0 when idle)
//                 bus_busy     - a grant is active
//                 hold_timeout - one-cycle pulse on excessive hold
//               master modport: requester side; slave modport: arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface coherence_bus_arbiter_if #(
    parameter int NUM_L1_CACHES = 4
);
    import coherence_bus_arbiter_pkg::*;

    localparam int BUS_PORTS     = NUM_L1_CACHES + 1;
    localparam int BUS_SIG_WIDTH = log2(BUS_PORTS);

    logic [BUS_PORTS-1:0]     request;
    logic [BUS_PORTS-1:0]     grant;
    logic [BUS_SIG_WIDTH-1:0] grant_id;
    logic                     bus_busy;
    logic                     hold_timeout;

    modport master (
        output request,
        input  grant,
        input  grant_id,
        input  bus_busy,
        input  hold_timeout
    );

    modport slave (
        input  request,
        output grant,
        output grant_id,
        output bus_busy,
        output hold_timeout
    );

endinterface : coherence_bus_arbiter_if
`default_nettype wire

// File: rtl/coherence_bus_arbiter_rr_priority_select.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_select
// Description : Combinational round-robin picker. Returns the first set
//               request bit at or after pointer, wrapping from WIDTH-1 to 0.
//                 requests - candidate request vector
//                 pointer  - search start position (must be < WIDTH)
//                 onehot   - selected request, one-hot
//                 index    - selected request position
//                 found    - any request was set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_select
    import coherence_bus_arbiter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = log2(WIDTH)
) (
    input  logic [WIDTH-1:0] requests,
    input  logic [IDX_W-1:0] pointer,
    output logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] index,
    output logic             found
);

    logic [2*WIDTH-1:0] w_dbl;
    logic [WIDTH-1:0]   w_rot;
    logic [IDX_W-1:0]   w_off;
    logic [IDX_W:0]     w_sum;

    // Rotate the requests so that bit 0 corresponds to the pointer, find the
    // first set bit, then rotate the offset back into an absolute index.
    always_comb begin
        w_dbl  = {requests, requests} >> pointer;
        w_rot  = w_dbl[WIDTH-1:0];
        w_off  = '0;
        found  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!found && w_rot[i]) begin
                found = 1'b1;
                w_off = IDX_W'(i);
            end
        end
        w_sum = {1'b0, pointer} + {1'b0, w_off};
        if (w_sum >= (IDX_W+1)'(WIDTH)) begin
            w_sum = w_sum - (IDX_W+1)'(WIDTH);
        end
        index  = w_sum[IDX_W-1:0];
        onehot = found ? (WIDTH'(1) << index) : '0;
    end

endmodule : rr_priority_select
`default_nettype wire

// File: rtl/coherence_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : coherence_bus_arbiter
// Description : Coherence bus arbiter for NUM_L1_CACHES L1 ports plus one
//               memory-side port. Memory has absolute priority in IDLE, L1
//               ports are served round-robin, a grant is non-preemptive and
//               is followed by one TURN cycle. A hold counter raises a
//               one-cycle hold_timeout after MAX_HOLD cycles of one grant.
//                 clock - rising-edge clock
//                 reset - asynchronous active-high reset
//                 bus   - request/grant bundle (slave modport)
// Revision    : 1.0 - initial release
// ============================================================================
module coherence_bus_arbiter
    import coherence_bus_arbiter_pkg::*;
#(
    parameter int NUM_L1_CACHES = 4,
    parameter int MAX_HOLD      = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    coherence_bus_arbiter_if.slave bus
);

    localparam int BUS_PORTS     = NUM_L1_CACHES + 1;
    localparam int MEM_PORT      = BUS_PORTS - 1;
    localparam int BUS_SIG_WIDTH = log2(BUS_PORTS);
    localparam int RR_W          = log2(NUM_L1_CACHES);
    localparam int CNT_W         = log2(MAX_HOLD + 1);

    localparam logic [CNT_W-1:0]         c_hold_max  = CNT_W'(MAX_HOLD);
    localparam logic [BUS_SIG_WIDTH-1:0] c_mem_id    = BUS_SIG_WIDTH'(MEM_PORT);
    localparam logic [BUS_SIG_WIDTH-1:0] c_last_l1   = BUS_SIG_WIDTH'(NUM_L1_CACHES - 1);

    arb_state_t               r_state, w_state_nx;
    logic [BUS_PORTS-1:0]     r_grant, w_grant_nx;
    logic [BUS_SIG_WIDTH-1:0] r_grant_id, w_grant_id_nx;
    logic                     r_busy, w_busy_nx;
    logic                     r_timeout, w_timeout_nx;
    logic [RR_W-1:0]          r_rr_ptr, w_rr_ptr_nx;
    logic [CNT_W-1:0]         r_hold_cnt, w_hold_cnt_nx;

    logic [NUM_L1_CACHES-1:0] w_pick_onehot;
    logic [RR_W-1:0]          w_pick_index;
    logic                     w_pick_found;

    rr_priority_select #(
        .WIDTH (NUM_L1_CACHES),
        .IDX_W (RR_W)
    ) u_rr_select (
        .requests (bus.request[NUM_L1_CACHES-1:0]),
        .pointer  (r_rr_ptr),
        .onehot   (w_pick_onehot),
        .index    (w_pick_index),
        .found    (w_pick_found)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_grant    <= w_grant_nx;
            r_grant_id <= w_grant_id_nx;
            r_busy     <= w_busy_nx;
            r_timeout  <= w_timeout_nx;
            r_rr_ptr   <= w_rr_ptr_nx;
            r_hold_cnt <= w_hold_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_grant_nx    = r_grant;
        w_grant_id_nx = r_grant_id;
        w_busy_nx     = r_busy;
        w_timeout_nx  = 1'b0;
        w_rr_ptr_nx   = r_rr_ptr;
        w_hold_cnt_nx = r_hold_cnt;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.request[MEM_PORT]) begin
                    w_state_nx             = ST_GRANT;
                    w_grant_nx             = '0;
                    w_grant_nx[MEM_PORT]   = 1'b1;
                    w_grant_id_nx          = c_mem_id;
                    w_busy_nx              = 1'b1;
                    w_hold_cnt_nx          = '0;
                end else if (w_pick_found) begin
                    w_state_nx    = ST_GRANT;
                    w_grant_nx    = {1'b0, w_pick_onehot};
                    w_grant_id_nx = BUS_SIG_WIDTH'(w_pick_index);
                    w_busy_nx     = 1'b1;
                    w_hold_cnt_nx = '0;
                end
            end

            ST_GRANT: begin
                if (bus.request[r_grant_id]) begin
                    // Non-preemptive: only the owner's request matters here.
                    if (r_hold_cnt < c_hold_max) begin
                        w_hold_cnt_nx = r_hold_cnt + 1'b1;
                    end
                    // Pulse lines up with the cycle the count reaches MAX_HOLD.
                    if (r_hold_cnt == c_hold_max - 1'b1) begin
                        w_timeout_nx = 1'b1;
                    end
                end else begin
                    w_state_nx    = ST_TURN;
                    w_grant_nx    = '0;
                    w_grant_id_nx = '0;
                    w_busy_nx     = 1'b0;
                    // The memory port sits outside the L1 rotation.
                    if (r_grant_id != c_mem_id) begin
                        if (r_grant_id == c_last_l1) begin
                            w_rr_ptr_nx = '0;
                        end else begin
                            w_rr_ptr_nx = RR_W'(r_grant_id + 1'b1);
                        end
                    end
                end
            end

            ST_TURN: begin
                w_state_nx = ST_IDLE;
            end

            default: begin
                w_state_nx    = ST_IDLE;
                w_grant_nx    = '0;
                w_grant_id_nx = '0;
                w_busy_nx     = 1'b0;
            end
        endcase
    end

    assign bus.grant        = r_grant;
    assign bus.grant_id     = r_grant_id;
    assign bus.bus_busy     = r_busy;
    assign bus.hold_timeout = r_timeout;

endmodule : coherence_bus_arbiter
`default_nettype wire

// File: tb/tb_coherence_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_coherence_bus_arbiter
// Description : Scoreboard bench for coherence_bus_arbiter. Requester agents
//               drive requests on the falling edge; a transaction-level model
//               predicts the bus state after the next rising edge and queues
//               it; a monitor pops and compares just after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coherence_bus_arbiter;
    import coherence_bus_arbiter_pkg::*;

    localparam int N    = 4;
    localparam int P    = N + 1;
    localparam int MEM  = N;
    localparam int MAXH = 4;
    localparam int IDW  = 3;

    typedef struct packed {
        logic [P-1:0]   grant;
        logic [IDW-1:0] id;
        logic           busy;
        logic           tout;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    coherence_bus_arbiter_if #(.NUM_L1_CACHES(N)) bus_if ();

    coherence_bus_arbiter #(
        .NUM_L1_CACHES (N),
        .MAX_HOLD      (MAXH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: who owns the bus, whether a dead cycle is pending,
    // where the L1 rotation starts and how long the owner has held.
    int   m_owner = -1;
    bit   m_turn  = 1'b0;
    int   m_ptr   = 0;
    int   m_held  = 0;

    // Requester agents.
    bit   want [P];
    int   rem  [P];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step(input logic [P-1:0] req, input logic rst);
        exp_t e;
        e = '0;
        if (rst) begin
            m_owner = -1; m_turn = 1'b0; m_ptr = 0; m_held = 0;
        end else if (m_owner >= 0) begin
            if (req[m_owner]) begin
                if (m_held < MAXH) begin
                    m_held++;
                    if (m_held == MAXH) e.tout = 1'b1;
                end
            end else begin
                if (m_owner != MEM) m_ptr = (m_owner + 1) % N;
                m_owner = -1;
                m_turn  = 1'b1;
            end
        end else if (m_turn) begin
            m_turn = 1'b0;
        end else begin
            if (req[MEM]) begin
                m_owner = MEM;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                end
            end
            m_held = 0;
        end
        if (m_owner >= 0) begin
            e.grant[m_owner] = 1'b1;
            e.id             = IDW'(m_owner);
            e.busy           = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    // One bus cycle: agents react to the current grant, inputs are applied
    // and the model predicts the post-edge outputs.
    task automatic step(input int pl1, input int pmem, input logic rst);
        logic [P-1:0] req;
        @(negedge clock);
        for (int p = 0; p < P; p++) begin
            if (want[p] && bus_if.grant[p]) begin
                rem[p]--;
                if (rem[p] <= 0) want[p] = 1'b0;
            end else if (!want[p] && !rst) begin
                if ($urandom_range(0, 99) < ((p == MEM) ? pmem : pl1)) begin
                    want[p] = 1'b1;
                    rem[p]  = $urandom_range(1, 7);
                end
            end
        end
        for (int p = 0; p < P; p++) req[p] = want[p];
        bus_if.request = req;
        if (rst && !reset) begin
            reset = 1'b1;
            #1;
            chk("async_reset_grant", 32'(bus_if.grant), 32'd0);
            chk("async_reset_busy", 32'(bus_if.bus_busy), 32'd0);
        end else begin
            reset = rst;
        end
        model_step(req, rst);
    endtask

    task automatic run(input int n, input int pl1, input int pmem);
        for (int c = 0; c < n; c++) step(pl1, pmem, 1'b0);
    endtask

    task automatic clear_agents();
        for (int p = 0; p < P; p++) begin
            want[p] = 1'b0;
            rem[p]  = 0;
        end
    endtask

    task automatic do_reset();
        clear_agents();
        step(0, 0, 1'b1);
        step(0, 0, 1'b1);
    endtask

    // Monitor: compare the DUT against the oldest prediction.
    always @(posedge clock) begin
        exp_t e;
        exp_t a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus_if.grant, bus_if.grant_id, bus_if.bus_busy, bus_if.hold_timeout};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL bus_state: got grant=%b id=%0d busy=%b tout=%b, expected grant=%b id=%0d busy=%b tout=%b at %0t",
                         a.grant, a.id, a.busy, a.tout, e.grant, e.id, e.busy, e.tout, $time);
            end
            checks++;
            if ($countones(bus_if.grant) > 1) begin
                errors++;
                $display("FAIL grant_onehot: got %b, expected at most one bit", bus_if.grant);
            end
        end
    end

    initial begin
        clear_agents();
        bus_if.request = '0;
        @(posedge clock);
        #1;
        chk("reset_grant", 32'(bus_if.grant), 32'd0);
        chk("reset_grant_id", 32'(bus_if.grant_id), 32'd0);
        chk("reset_busy", 32'(bus_if.bus_busy), 32'd0);
        chk("reset_timeout", 32'(bus_if.hold_timeout), 32'd0);
        do_reset();

        // Single L1 requester holding for three grant cycles.
        want[0] = 1'b1; rem[0] = 3;
        run(8, 0, 0);

        // All L1 ports requesting continuously, two grant cycles each.
        for (int p = 0; p < N; p++) begin
            want[p] = 1'b1; rem[p] = 2;
        end
        for (int c = 0; c < 16; c++) begin
            for (int p = 0; p < N; p++) if (!want[p]) begin want[p] = 1'b1; rem[p] = 2; end
            step(0, 0, 1'b0);
        end
        clear_agents();
        run(4, 0, 0);

        // Memory beats an L1 port; the rotation pointer is left alone.
        do_reset();
        want[3] = 1'b1; rem[3] = 3;
        want[4] = 1'b1; rem[4] = 3;
        run(12, 0, 0);
        want[0] = 1'b1; rem[0] = 2;
        want[1] = 1'b1; rem[1] = 2;
        run(10, 0, 0);

        // Memory request arriving mid-grant does not preempt.
        want[2] = 1'b1; rem[2] = 4;
        run(2, 0, 0);
        want[4] = 1'b1; rem[4] = 2;
        run(12, 0, 0);

        // Long hold triggers a single timeout pulse.
        want[1] = 1'b1; rem[1] = 10;
        run(16, 0, 0);

        // Reset while port 3 owns the bus, then a fresh grant.
        want[3] = 1'b1; rem[3] = 20;
        run(4, 0, 0);
        do_reset();
        want[3] = 1'b1; rem[3] = 2;
        run(6, 0, 0);

        // Randomized traffic with occasional resets.
        for (int blk = 0; blk < 5; blk++) begin
            run(400, 30, 8);
            do_reset();
        end
        run(300, 60, 20);

        clear_agents();
        run(12, 0, 0);
        @(posedge clock);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_coherence_bus_arbiter
`default_nettype wire
